// File: rtl/blink_controller_if.sv
// Config handshake bundle for blink_controller: half-period and burst length
// offered with valid, accepted when the sequencer is idle.
interface blink_controller_if #(
  parameter int CNT_W   = 26,
  parameter int BURST_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_half_period;
  logic [BURST_W-1:0] cfg_burst;

  modport master (output cfg_valid, cfg_half_period, cfg_burst, input cfg_ready);
  modport slave  (input cfg_valid, cfg_half_period, cfg_burst, output cfg_ready);
endinterface

// File: rtl/blink_controller.sv
// LED blink sequencer: half-period counter plus toggle flop under config/start/stop.
// Optional BLINK_PAUSE_EN adds a pause input that freezes a running blink.
module blink_controller #(
  parameter int CNT_W        = 26,
  parameter int DEFAULT_HALF = 25000000,
  parameter int BURST_W      = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  blink_controller_if.slave cfg,
  input  logic              start,
  input  logic              stop,
`ifdef BLINK_PAUSE_EN
  input  logic              pause,
`endif
  output logic [1:0]        LED,
  output logic              busy,
  output logic              done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic [CNT_W-1:0]   half_reg;
  logic [BURST_W-1:0] burst_reg;
  logic [CNT_W-1:0]   cnt;
  logic [BURST_W-1:0] remaining;
  logic               led_on;

  logic               cfg_fire;
  logic [CNT_W-1:0]   new_half;
  logic [BURST_W-1:0] run_burst;
  logic               at_top;
  logic               hold;

`ifdef BLINK_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign cfg.cfg_ready = (state == IDLE);
  assign cfg_fire      = cfg.cfg_valid && (state == IDLE);
  // A zero half-period would never match the compare; treat it as one clock.
  assign new_half      = (cfg.cfg_half_period == '0) ? CNT_W'(1) : cfg.cfg_half_period;
  // Config landing on the start edge must govern the run it starts.
  assign run_burst     = cfg_fire ? cfg.cfg_burst : burst_reg;
  assign at_top        = (cnt == half_reg - CNT_W'(1));
  assign LED           = {~led_on, led_on};

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      half_reg  <= CNT_W'(DEFAULT_HALF);
      burst_reg <= '0;
      cnt       <= '0;
      remaining <= '0;
      led_on    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_fire) begin
            half_reg  <= new_half;
            burst_reg <= cfg.cfg_burst;
          end
          if (start) begin
            state     <= RUN;
            cnt       <= '0;
            led_on    <= 1'b0;
            remaining <= run_burst;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state  <= IDLE;
            cnt    <= '0;
            led_on <= 1'b0;
            busy   <= 1'b0;
          end else if (!hold) begin
            if (at_top) begin
              cnt    <= '0;
              led_on <= ~led_on;
              // Falling toggle closes one on/off cycle of a finite burst.
              if (led_on && burst_reg != '0) begin
                remaining <= remaining - BURST_W'(1);
                if (remaining == BURST_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_controller.sv
// Scoreboard bench for blink_controller: a driver pushes per-edge expectations
// from an elapsed-edge model; a monitor pops and compares after each edge.
module tb_blink_controller;
  localparam int CNT_W = 26;
  localparam int BURST_W = 8;
  localparam int DEF_HALF = 25000000;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] LED;
  logic       busy, done;

  blink_controller_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) cif ();

  blink_controller #(.CNT_W(CNT_W), .DEFAULT_HALF(DEF_HALF), .BURST_W(BURST_W)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .cfg      (cif),
    .start    (start),
    .stop     (stop),
`ifdef BLINK_PAUSE_EN
    .pause    (pause),
`endif
    .LED      (LED),
    .busy     (busy),
    .done     (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [1:0] led;
    logic       busy;
    logic       done;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Model: a run is just "edges elapsed k" at half-period H and burst B.
  bit     m_run = 0;
  longint m_half = DEF_HALF;
  longint m_burst = 0;
  longint m_k = 0;
  bit     m_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_half = DEF_HALF; m_burst = 0; m_k = 0; m_done = 0;
  endtask

  // Drive one edge worth of inputs, push the expected post-edge outputs, advance.
  task automatic step(input bit cv, input int hp, input int b,
                      input bit st, input bit sp, input bit pz);
    exp_t e;
    bit   pz_eff;
    bit   l0;
`ifdef BLINK_PAUSE_EN
    pz_eff = pz;
`else
    pz_eff = 1'b0;
`endif
    cif.cfg_valid = cv;
    cif.cfg_half_period = CNT_W'(hp);
    cif.cfg_burst = BURST_W'(b);
    start = st; stop = sp; pause = pz_eff;
    if (!reset) model_reset();
    else begin
      m_done = 0;
      if (!m_run) begin
        if (cv) begin m_half = (hp == 0) ? 1 : hp; m_burst = b; end
        if (st) begin m_run = 1; m_k = 0; end
      end else if (sp) m_run = 0;
      else if (!pz_eff) begin
        m_k++;
        if (m_burst != 0 && m_k == 2 * m_burst * m_half) begin m_run = 0; m_done = 1; end
      end
    end
    l0 = m_run ? bit'((m_k / m_half) % 2) : 1'b0;
    e.led = {~l0, l0}; e.busy = m_run; e.done = m_done; e.rdy = ~m_run;
    sb.push_back(e);
    @(posedge CLOCK_50); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic go(input int hp, input int b);
    step(1, hp, b, 1, 0, 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge CLOCK_50); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("LED", 32'(LED), 32'(e.led));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("cfg_ready", 32'(cif.cfg_ready), 32'(e.rdy));
      end
    end
  end

  initial begin
    cif.cfg_valid = 0; cif.cfg_half_period = '0; cif.cfg_burst = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_LED", 32'(LED), 32'd2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_ready", 32'(cif.cfg_ready), 32'd1);
    #1 reset = 1'b1;

    // Default half-period: LED stays low through a truncated window.
    step(0, 0, 0, 1, 0, 0);
    idle(150);
    step(0, 0, 0, 0, 1, 0);
    idle(3);

    // H=4 burst=2
    go(4, 2);
    idle(20);

    // H=4 continuous, 100 cycles, then stop
    go(4, 0);
    idle(100);
    step(0, 0, 0, 0, 1, 0);
    idle(3);

    // H=0 behaves as H=1, burst 3
    go(0, 3);
    idle(10);

    // Config offered mid-run is ignored; IDLE transfer applies to next start
    go(4, 0);
    idle(5);
    for (int i = 0; i < 12; i++) step(1, 8, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 8, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(20);

    // start+stop together in IDLE, then stop held
    step(1, 3, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(2);

    // Pause at cnt=2 for 10 cycles (no-op without the pause feature)
    go(4, 0);
    idle(2);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1);
    idle(8);
    step(0, 0, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0);
    step(0, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-run
    go(4, 5);
    idle(6);
    reset = 1'b0;
    #1;
    chk("async_rst_LED", 32'(LED), 32'd2);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_cfg_ready", 32'(cif.cfg_ready), 32'd1);
    idle(2);
    reset = 1'b1;
    step(0, 0, 0, 1, 0, 0);
    idle(5);
    step(0, 0, 0, 0, 1, 0);
    idle(2);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
